inst_fetch_responder: RTL

Memory-side responder for the instruction-fetch interface. Accepts one word-aligned fetch request at a time from the fetch stage, returns the instruction word after a fixed, parameterized latency, and signals its own readiness so the fetch stage can derive its freeze. Sits between the fetch stage and the instruction store; a write port loads the program image.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/inst_ram.sv | 26 ++
 rtl/inst_fetch_responder.sv | 117 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch responder.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } fetch_state_t;

  localparam int INST_W = 32;
  localparam logic [INST_W-1:0] ERR_INST = 32'h0000_0000;

endpackage

// File: rtl/inst_ram.sv
// Instruction store: synchronous write port for program load, asynchronous read for fetch.
module inst_ram
  import fetch_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [INST_W-1:0]        wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [INST_W-1:0]        rd_data
);

  logic [INST_W-1:0] mem_r [DEPTH];

  // Program-load write; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/inst_fetch_responder.sv
// Fixed-latency instruction-fetch responder: one outstanding request, flushable,
// with a write port for loading the program image.
module inst_fetch_responder
  import fetch_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [31:0]       req_addr,
  output logic              req_ready,
  input  logic              flush,
  output logic              resp_valid,
  output logic [INST_W-1:0] resp_inst,
  output logic [31:0]       resp_pc,
  output logic              resp_err,
  input  logic              wr_en,
  input  logic [31:0]       wr_addr,
  input  logic [INST_W-1:0] wr_data
);

  localparam int AW = $clog2(DEPTH);
  localparam fetch_state_t ACC_STATE = fetch_state_t'((LATENCY == 1) ? RESP : WAIT);

  fetch_state_t      state_r;
  fetch_state_t      state_nxt_s;
  logic [3:0]        cnt_r;
  logic [31:0]       pc_r;
  logic [INST_W-1:0] inst_r;
  logic              err_r;
  logic              accept_s;
  logic              req_err_s;
  logic              wr_in_range_s;
  logic [INST_W-1:0] rd_data_s;
  logic              unused_s;

  assign accept_s      = req_valid && req_ready;
  assign req_err_s     = (req_addr[1:0] != 2'b00) || (req_addr[31:2] >= 30'(DEPTH));
  assign wr_in_range_s = wr_en && (wr_addr[31:2] < 30'(DEPTH));
  assign unused_s      = ^wr_addr[1:0];

  inst_ram #(.DEPTH(DEPTH)) u_ram (
    .clk     (clk),
    .wr_en   (wr_in_range_s),
    .wr_addr (wr_addr[AW+1:2]),
    .wr_data (wr_data),
    .rd_addr (req_addr[AW+1:2]),
    .rd_data (rd_data_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; acceptance in RESP restarts the sequence directly.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_nxt_s = ACC_STATE;
        else          state_nxt_s = IDLE;
      end
      WAIT: begin
        if (flush)               state_nxt_s = IDLE;
        else if (cnt_r == 4'd1)  state_nxt_s = RESP;
        else                     state_nxt_s = WAIT;
      end
      RESP: begin
        if (accept_s) state_nxt_s = ACC_STATE;
        else          state_nxt_s = IDLE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Handshake outputs depend only on state and flush.
  always_comb begin
    req_ready  = 1'b1;
    resp_valid = 1'b0;
    case (state_r)
      IDLE:    req_ready = 1'b1;
      WAIT:    req_ready = 1'b0;
      RESP:    resp_valid = !flush;
      default: req_ready = 1'b1;
    endcase
  end

  // Latency counter and response holding registers; store data is sampled
  // before the same-edge write lands, so a colliding write returns old data.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r  <= 4'd0;
      pc_r   <= 32'h0000_0000;
      inst_r <= ERR_INST;
      err_r  <= 1'b0;
    end else if (accept_s) begin
      cnt_r  <= 4'(LATENCY - 1);
      pc_r   <= req_addr;
      err_r  <= req_err_s;
      inst_r <= req_err_s ? ERR_INST : rd_data_s;
    end else if ((state_r == WAIT) && (cnt_r != 4'd0)) begin
      cnt_r <= cnt_r - 4'd1;
    end
  end

  assign resp_pc   = pc_r;
  assign resp_inst = inst_r;
  assign resp_err  = err_r;

endmodule
